// File: rtl/pci_pkg.sv
// Shared PCI bus constants and initiator state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a; the target model imports the same command codes.
package pci_pkg;

    // C/BE# encodings: bus commands in the address phase, byte enables in data phases.
    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
    localparam logic [3:0] BE_ALL        = 4'b0000;
    localparam logic [3:0] CBE_IDLE      = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_TURN = 2'd3
    } state_t;

endpackage

// File: rtl/pci_initiator.sv
// PCI memory read/write burst initiator with DEVSEL master-abort timeout.
// Latency: request -> 1 address cycle -> data beats -> 1 turnaround cycle with DONE.
// Backpressure: target wait states (TRDY high) are absorbed without limit once DEVSEL is seen.
//
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   REQ_START/WRITE/ADDR/LEN      local request, latched on an accepted REQ_START
//   WDATA, WDATA_ACK              write beat source and its per-beat acknowledge
//   RDATA, RDATA_VALID            captured read beat and its qualifier
//   BUSY, DONE, ERR               status; ERR qualifies DONE and flags a master abort
//   FRAME, IRDY, CBE, AD          PCI initiator signals (active-low FRAME/IRDY, AD tri-state)
//   TRDY, DEVSEL                  PCI target responses (active-low)
module pci_initiator
    import pci_pkg::*;
#(
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int MAX_BEATS      = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_START,
    input  logic        REQ_WRITE,
    input  logic [31:0] REQ_ADDR,
    input  logic [3:0]  REQ_LEN,
    input  logic [31:0] WDATA,
    output logic        WDATA_ACK,
    output logic [31:0] RDATA,
    output logic        RDATA_VALID,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        FRAME,
    output logic        IRDY,
    output logic [3:0]  CBE,
    inout  wire  [31:0] AD,
    input  logic        TRDY,
    input  logic        DEVSEL
);

    // Timeout counter only needs to reach DEVSEL_TIMEOUT-1; the abort fires on that cycle.
    localparam int TW = (DEVSEL_TIMEOUT < 2) ? 1 : $clog2(DEVSEL_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST  = TW'(DEVSEL_TIMEOUT - 1);
    localparam logic [4:0]    MAX_LEN   = 5'(MAX_BEATS);

    state_t        state_q,  state_d;
    logic [31:0]   addr_q,   addr_d;
    logic          write_q,  write_d;
    logic [3:0]    rem_q,    rem_d;
    logic [TW-1:0] tmo_q,    tmo_d;
    logic          dsel_q,   dsel_d;
    logic          err_q,    err_d;
    logic          wack_q,   wack_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q,  rdata_d;

    logic        len_ok;
    logic        xfer;
    logic        ad_oe;
    logic [31:0] ad_out;

    assign len_ok = (REQ_LEN != 4'd0) && ({1'b0, REQ_LEN} <= MAX_LEN);
    // IRDY is always asserted in DATA, so a beat moves whenever the target is ready and selected.
    assign xfer   = (state_q == ST_DATA) && !TRDY && !DEVSEL;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        rem_d    = rem_q;
        tmo_d    = tmo_q;
        dsel_d   = dsel_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        wack_d   = 1'b0;
        rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ_START && len_ok) begin
                    state_d = ST_ADDR;
                    addr_d  = REQ_ADDR;
                    write_d = REQ_WRITE;
                    rem_d   = REQ_LEN;
                    err_d   = 1'b0;
                end
            end
            ST_ADDR: begin
                state_d = ST_DATA;
                tmo_d   = '0;
                dsel_d  = 1'b0;
            end
            ST_DATA: begin
                if (!DEVSEL) begin
                    dsel_d = 1'b1;
                end
                if (xfer) begin
                    rem_d    = 4'(rem_q - 4'd1);
                    wack_d   = write_q;
                    rvalid_d = !write_q;
                    if (!write_q) begin
                        rdata_d = AD;
                    end
                    if (rem_q == 4'd1) begin
                        state_d = ST_TURN;
                    end
                end else if (!dsel_q && DEVSEL) begin
                    // Counter stops advancing for good once DEVSEL has been seen low.
                    if (tmo_q == TMO_LAST) begin
                        state_d = ST_TURN;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = TW'(tmo_q + 1'b1);
                    end
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            rem_q    <= '0;
            tmo_q    <= '0;
            dsel_q   <= 1'b0;
            err_q    <= 1'b0;
            wack_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            rem_q    <= rem_d;
            tmo_q    <= tmo_d;
            dsel_q   <= dsel_d;
            err_q    <= err_d;
            wack_q   <= wack_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Bus outputs decode straight from the state register so an asynchronous reset
    // releases AD and deasserts FRAME/IRDY in the same cycle.
    always_comb begin
        FRAME  = 1'b1;
        IRDY   = 1'b1;
        CBE    = CBE_IDLE;
        ad_oe  = 1'b0;
        ad_out = WDATA;
        case (state_q)
            ST_ADDR: begin
                FRAME  = 1'b0;
                CBE    = write_q ? CMD_MEM_WRITE : CMD_MEM_READ;
                ad_oe  = 1'b1;
                ad_out = addr_q;
            end
            ST_DATA: begin
                // FRAME goes high alongside the final beat, including a single-beat burst.
                FRAME = (rem_q == 4'd1);
                IRDY  = 1'b0;
                CBE   = BE_ALL;
                // Reads leave AD floating for the whole data phase; the first cycle is turnaround.
                ad_oe = write_q;
            end
            default: begin
            end
        endcase
    end

    assign AD          = ad_oe ? ad_out : {32{1'bz}};
    assign BUSY        = (state_q != ST_IDLE);
    assign DONE        = (state_q == ST_TURN);
    assign ERR         = (state_q == ST_TURN) && err_q;
    assign WDATA_ACK   = wack_q;
    assign RDATA_VALID = rvalid_q;
    assign RDATA       = rdata_q;

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: bench-side target model plus event scoreboard.
// Latency: checks address phase, per-beat FRAME/IRDY/CBE, and DONE cycle position.
// Backpressure: target inserts turnaround and wait states; writes get a gap after each beat.
module tb_pci_initiator;
    import pci_pkg::*;

    localparam int TMO = 5;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    localparam int EV_WBEAT = 1;
    localparam int EV_RBEAT = 2;
    localparam int EV_WACK  = 3;
    localparam int EV_DONE  = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_START = 1'b0;
    logic        REQ_WRITE = 1'b0;
    logic [31:0] REQ_ADDR = '0;
    logic [3:0]  REQ_LEN = '0;
    logic [31:0] WDATA = '0;
    logic        WDATA_ACK;
    logic [31:0] RDATA;
    logic        RDATA_VALID;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic        FRAME;
    logic        IRDY;
    logic [3:0]  CBE;
    logic        TRDY = 1'b1;
    logic        DEVSEL = 1'b1;

    // Pulled-up bus: an undriven AD reads as all ones.
    tri1  [31:0] ad_bus;
    logic        tgt_drive = 1'b0;
    logic [31:0] tgt_ad = '0;
    assign ad_bus = tgt_drive ? tgt_ad : {32{1'bz}};

    typedef struct {
        int          kind;
        logic [31:0] dat;
    } evt_t;
    evt_t sb[$];

    int          total = 0;
    int          bad = 0;
    logic [31:0] beat_dat[16];
    int          widx = 0;
    logic        cur_wr = 1'b0;

    pci_initiator #(.DEVSEL_TIMEOUT(TMO), .MAX_BEATS(15)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_START(REQ_START), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
        .WDATA(WDATA), .WDATA_ACK(WDATA_ACK),
        .RDATA(RDATA), .RDATA_VALID(RDATA_VALID),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .FRAME(FRAME), .IRDY(IRDY), .CBE(CBE), .AD(ad_bus),
        .TRDY(TRDY), .DEVSEL(DEVSEL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] dat);
        evt_t e;
        e.kind = kind;
        e.dat  = dat;
        sb.push_back(e);
    endtask

    task automatic check_evt(input int kind, input logic [31:0] dat);
        evt_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got event %0d data %h want none", kind, dat);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_data", dat, e.dat);
        end
    endtask

    // Monitor: independent of stimulus, pops one expectation per observed DUT event.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (!RST) begin
                if (!IRDY && !TRDY && !DEVSEL && cur_wr) check_evt(EV_WBEAT, ad_bus);
                if (RDATA_VALID) check_evt(EV_RBEAT, RDATA);
                if (WDATA_ACK) check_evt(EV_WACK, 32'd0);
                if (DONE) check_evt(EV_DONE, {31'd0, ERR});
            end
        end
    end

    // Local write-data source: advances to the next beat the cycle after each acknowledge.
    initial begin
        forever begin
            @(negedge CLK);
            if (WDATA_ACK) begin
                @(posedge CLK);
                #1;
                if (widx < 15) widx++;
                WDATA = beat_dat[widx];
            end
        end
    end

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            @(negedge CLK);
            chk_b("idle_busy", BUSY, 1'b0);
            chk_b("idle_frame", FRAME, 1'b1);
            chk_b("idle_irdy", IRDY, 1'b1);
            chk("idle_cbe", {28'd0, CBE}, {28'd0, CBE_IDLE});
            chk("idle_ad", ad_bus, ONES);
        end
    endtask

    // One transaction with the bench acting as target. rst_beat >= 0 asserts reset just
    // before that beat would transfer; busy_cyc pulses REQ_START in that cycle index
    // (request cycle = 0); exp_done > 0 fixes the cycle index DONE must appear in.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input int len,
                           input logic respond, input int wait_beat, input int nwait,
                           input int rst_beat, input int busy_cyc, input int exp_done);
        int   b     = 0;
        int   waits = 0;
        int   cyc   = 0;
        logic gap   = 1'b0;
        logic first = 1'b1;
        logic fin   = 1'b0;
        @(posedge CLK);
        #1;
        cur_wr    = wr;
        widx      = 0;
        WDATA     = beat_dat[0];
        REQ_START = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_LEN   = len[3:0];
        if (!respond) push(EV_DONE, 32'd1);
        @(posedge CLK);
        #1;
        REQ_START = 1'b0;
        cyc = 1;
        @(negedge CLK);
        chk_b("addr_frame", FRAME, 1'b0);
        chk_b("addr_irdy", IRDY, 1'b1);
        chk("addr_cbe", {28'd0, CBE}, {28'd0, wr ? CMD_MEM_WRITE : CMD_MEM_READ});
        chk("addr_ad", ad_bus, addr);
        chk_b("addr_busy", BUSY, 1'b1);
        while (!fin && cyc < 40) begin
            @(posedge CLK);
            #1;
            cyc++;
            REQ_START = (cyc == busy_cyc);
            if (cyc == busy_cyc) REQ_ADDR = 32'hDEAD_0000;
            tgt_drive = 1'b0;
            DEVSEL    = 1'b1;
            TRDY      = 1'b1;
            if (!IRDY) begin
                if (respond) begin
                    DEVSEL = 1'b0;
                    if (first && !wr) begin
                    end else if (gap) begin
                    end else if (b == wait_beat && waits < nwait) begin
                        waits++;
                    end else begin
                        TRDY = 1'b0;
                        if (!wr) begin
                            tgt_drive = 1'b1;
                            tgt_ad    = beat_dat[b];
                        end
                    end
                end
                first = 1'b0;
                gap   = 1'b0;
            end
            @(negedge CLK);
            if (DONE) begin
                if (exp_done > 0) chk("done_cycle", cyc, exp_done);
                chk_b("turn_frame", FRAME, 1'b1);
                chk_b("turn_irdy", IRDY, 1'b1);
                chk("turn_ad", ad_bus, ONES);
                fin = 1'b1;
            end else if (!IRDY) begin
                chk_b("data_frame", FRAME, (len - b) == 1);
                chk("data_cbe", {28'd0, CBE}, {28'd0, BE_ALL});
                if (!wr && !tgt_drive) chk("data_rd_ad_z", ad_bus, ONES);
                if (!TRDY && !DEVSEL) begin
                    if (b == rst_beat) begin
                        #1;
                        RST = 1'b1;
                        #1;
                        chk_b("rst_frame", FRAME, 1'b1);
                        chk_b("rst_irdy", IRDY, 1'b1);
                        chk("rst_ad", ad_bus, ONES);
                        chk_b("rst_busy", BUSY, 1'b0);
                        fin = 1'b1;
                    end else begin
                        if (wr) begin
                            push(EV_WBEAT, beat_dat[b]);
                            push(EV_WACK, 32'd0);
                        end else begin
                            push(EV_RBEAT, beat_dat[b]);
                        end
                        b++;
                        gap = wr;
                        if (b == len) push(EV_DONE, 32'd0);
                    end
                end
            end else begin
                chk_b("stray_busy", BUSY, 1'b0);
                fin = 1'b1;
            end
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL txn_timeout: got no DONE within %0d cycles want DONE", cyc);
        end
        tgt_drive = 1'b0;
        DEVSEL    = 1'b1;
        TRDY      = 1'b1;
        REQ_START = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) beat_dat[i] = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_b("rst_frame0", FRAME, 1'b1);
        chk_b("rst_irdy0", IRDY, 1'b1);
        chk("rst_cbe0", {28'd0, CBE}, 32'h0000_000F);
        chk("rst_ad0", ad_bus, ONES);
        chk_b("rst_busy0", BUSY, 1'b0);
        chk_b("rst_done0", DONE, 1'b0);
        chk_b("rst_err0", ERR, 1'b0);
        chk_b("rst_wack0", WDATA_ACK, 1'b0);
        chk_b("rst_rvalid0", RDATA_VALID, 1'b0);
        chk("rst_rdata0", RDATA, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Single-beat write, target ready in the first data cycle: DONE in cycle 3
        beat_dat[0] = 32'hA5A5_0001;
        run_txn(1'b1, 32'h0000_0000, 1, 1'b1, -1, 0, -1, -1, 3);
        idle_check(2);

        // Four-beat read: turnaround in cycle 2, beats in 3, 6, 7, 8 (beat 2 waits twice) -> DONE 9
        beat_dat[0] = 32'h10; beat_dat[1] = 32'h11; beat_dat[2] = 32'h12; beat_dat[3] = 32'h13;
        run_txn(1'b0, 32'h0000_1000, 4, 1'b1, 1, 2, -1, -1, 9);
        idle_check(2);

        // No target: abort after TMO data cycles -> DONE/ERR in cycle 1+TMO+1; REQ_START in TURN ignored
        run_txn(1'b0, 32'h0000_2000, 2, 1'b0, -1, 0, -1, 2 + TMO, 2 + TMO);
        idle_check(3);

        // Zero-length request is ignored
        @(posedge CLK);
        #1;
        REQ_START = 1'b1;
        REQ_WRITE = 1'b1;
        REQ_ADDR  = 32'h0000_4000;
        REQ_LEN   = 4'd0;
        @(posedge CLK);
        #1;
        REQ_START = 1'b0;
        @(negedge CLK);
        chk_b("len0_busy", BUSY, 1'b0);
        chk_b("len0_frame", FRAME, 1'b1);
        idle_check(3);

        // Two-beat write with a REQ_START pulse mid-burst: beats in cycles 2 and 4 -> DONE 5
        beat_dat[0] = 32'hC0DE_0001; beat_dat[1] = 32'hC0DE_0002;
        run_txn(1'b1, 32'h0000_5000, 2, 1'b1, -1, 0, -1, 3, 5);
        idle_check(3);

        // Reset just before beat 2 of a four-beat write
        beat_dat[0] = 32'h1111_0000; beat_dat[1] = 32'h1111_0001;
        beat_dat[2] = 32'h1111_0002; beat_dat[3] = 32'h1111_0003;
        run_txn(1'b1, 32'h0000_3000, 4, 1'b1, -1, 0, 1, -1, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle_check(2);

        // Recovery: two-beat read after reset -> DONE 5
        beat_dat[0] = 32'h0000_0077; beat_dat[1] = 32'h0000_0088;
        run_txn(1'b0, 32'h0000_6000, 2, 1'b1, -1, 0, -1, -1, 5);
        idle_check(2);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
